ads1292_frame_serializer: RTL and testbench
===========================================

Name: ads1292_frame_serializer

Overview:
- Sits between the ADS1292 read-data-continuous frame source and ads1292_filter.
- Buffers whole ADS1292 frames of status plus N_CH channels in a small FIFO.
- Serializes each buffered frame into one sign-extended word per channel, tagged with its channel index, on a valid/ack handshake.
- Parametrised successor of the single-channel 32-bit feed: generalised in channel count, sample and output width, and buffer depth, with overflow accounting.

Parameters:
- N_CH, 2, channels per frame (1..8).
- SAMPLE_W, 24, bits per channel sample, two's complement.
- STATUS_W, 24, status header bits at the frame MSB end.
- OUT_W, 32, output word width; OUT_W >= SAMPLE_W.
- DEPTH, 4, frame FIFO depth; power of two, >= 2.

Ports:
- i_CLK  in  1  clock
- i_RSTN  in  1  asynchronous active-low reset
- i_ADS1292_DATA_OUT  in  STATUS_W+N_CH*SAMPLE_W  frame: status, ch0, ch1... from MSB down
- i_ADS1292_DATA_VALID  in  1  one-cycle frame strobe; no backpressure
- o_SAMPLE_DATA  out  OUT_W  sign-extended channel sample
- o_SAMPLE_CH  out  $clog2(N_CH) (min 1)  channel index of o_SAMPLE_DATA
- o_SAMPLE_VALID  out  1  word valid
- i_SAMPLE_ACK  in  1  consumer accepts word
- o_FIFO_LEVEL  out  $clog2(DEPTH)+1  frames buffered
- o_OVERFLOW_CNT  out  16  frames dropped because FIFO full, saturating
- o_BAD_FRAME_CNT  out  16  frames dropped by status check, saturating

Behaviour:
- Reset (i_RSTN low, asynchronous): all outputs 0, FIFO empty, FSM in IDLE. Reset mid-frame discards the in-flight frame and all buffered frames.
- Write: i_ADS1292_DATA_VALID sampled high at edge k writes the frame if the FIFO is not full. If full, the frame is dropped and o_OVERFLOW_CNT increments, saturating at 0xFFFF.
- Write and pop at the same edge while full: the pop frees a slot, so the write is accepted.
- FSM IDLE: FIFO not empty -> pop head into shift register, load ch0, set o_SAMPLE_VALID, go to EMIT.
- FSM EMIT:
  - Hold o_SAMPLE_DATA, o_SAMPLE_CH and o_SAMPLE_VALID stable until an edge where valid and ack are both high (transfer).
  - Transfer on ch < N_CH-1: present ch+1 next cycle.
  - Transfer on ch = N_CH-1 with FIFO not empty: pop and present the next frame's ch0 next cycle, with no bubble.
  - Transfer on ch = N_CH-1 with FIFO empty: drop valid, go to IDLE.
- Latency: strobe in cycle 0 with FIFO empty and FSM idle -> o_SAMPLE_VALID high in cycle 2.
- Arithmetic: o_SAMPLE_DATA = sample[SAMPLE_W-1] replicated (OUT_W-SAMPLE_W) times, concatenated with the sample. The status field is never output.
- Ack while valid is low: ignored.
- o_FIFO_LEVEL: counts 0..DEPTH and updates on the edge of the write or pop.

Optional Feature:
- ADS1292_STATUS_CHECK_EN defined: a frame whose status[STATUS_W-1 -: 4] != 4'b1100 is dropped before the FIFO, and o_BAD_FRAME_CNT increments, saturating. A bad frame does not also increment o_OVERFLOW_CNT.
- Not defined: every frame is accepted subject to capacity, and o_BAD_FRAME_CNT is tied to 0.

Decomposition:
- ads1292_pkg: STATUS_SYNC_NIBBLE = 4'b1100; FSM state enum {IDLE, EMIT}; counter width constant CNT_W = 16.
- Sub-module ads1292_frame_fifo: synchronous FIFO parametrised by width and DEPTH, with full/empty/level outputs. The serializer FSM, sign extension and counters live in the top.

Test Plan:
- Single frame: status 0xC00000, ch0 0x800001, ch1 0x123456, ack held 1 -> ch0 word 0xFF800001 in cycle 2, then ch1 word 0x00123456 in cycle 3; valid low in cycle 4.
- Backpressure: ack low for 5 cycles after valid rises -> data and ch held stable; transfer on the first ack cycle; level returns to 0.
- Overflow: ack held 0, six strobes at DEPTH=4 -> one frame popped into the shift register, level 4, o_OVERFLOW_CNT = 1; all five buffered frames then drain in order.
- Back-to-back frames: two strobes one cycle apart, ack held 1 -> four consecutive valid cycles, ch sequence 0,1,0,1, no bubble.
- Reset mid-operation: i_RSTN low during a ch0 hold with 2 frames buffered -> valid, level and counters all 0 immediately; nothing emitted after release until a new strobe.
- Status check (macro on): status 0x400000 -> no output, o_BAD_FRAME_CNT = 1. Macro off -> frame emitted normally and o_BAD_FRAME_CNT stays 0.

Source files
------------

// File: rtl/ads1292_pkg.sv
// Shared constants and types for the ADS1292 frame serializer.
// Status sync nibble, serializer FSM states and the width of the drop counters.
package ads1292_pkg;

  localparam logic [3:0] STATUS_SYNC_NIBBLE = 4'b1100;
  localparam int         CNT_W              = 16;

  typedef enum logic {
    IDLE,
    EMIT
  } ser_state_e;

  // Saturating increment for the drop counters.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/ads1292_frame_fifo.sv
// Synchronous frame FIFO with combinational head read and registered level.
// A write arriving while full is accepted only when a pop happens on the same edge.
module ads1292_frame_fifo #(
  parameter int W     = 48,
  parameter int DEPTH = 4,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         wr_en_i,
  input  logic [W-1:0] wr_dat_i,
  input  logic         rd_en_i,
  output logic [W-1:0] rd_dat_o,
  output logic         full_o,
  output logic         empty_o,
  output logic [AW:0]  level_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [AW:0]   level_q;
  logic          wr_fire;
  logic          rd_fire;

  assign full_o   = (level_q == (AW+1)'(DEPTH));
  assign empty_o  = (level_q == '0);
  assign level_o  = level_q;
  assign rd_dat_o = mem_q[rd_ptr_q];

  assign rd_fire = rd_en_i && !empty_o;
  assign wr_fire = wr_en_i && (!full_o || rd_fire);

  always_ff @(posedge clk_i) begin
    if (wr_fire) begin
      mem_q[wr_ptr_q] <= wr_dat_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (wr_fire) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (rd_fire) rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({wr_fire, rd_fire})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/ads1292_frame_serializer.sv
// Buffers ADS1292 frames and emits one sign-extended word per channel on a valid/ack handshake; first word 2 cycles after strobe.
// Frames drop (counted) when the FIFO is full; optional ADS1292_STATUS_CHECK_EN drops frames with a bad status sync nibble.
module ads1292_frame_serializer
  import ads1292_pkg::*;
#(
  parameter int  N_CH     = 2,
  parameter int  SAMPLE_W = 24,
  parameter int  STATUS_W = 24,
  parameter int  OUT_W    = 32,
  parameter int  DEPTH    = 4,
  localparam int FRAME_W  = STATUS_W + N_CH*SAMPLE_W,
  localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1,
  localparam int LVL_W    = $clog2(DEPTH) + 1
) (
  input  logic               i_CLK,
  input  logic               i_RSTN,
  input  logic [FRAME_W-1:0] i_ADS1292_DATA_OUT,
  input  logic               i_ADS1292_DATA_VALID,
  output logic [OUT_W-1:0]   o_SAMPLE_DATA,
  output logic [CH_W-1:0]    o_SAMPLE_CH,
  output logic               o_SAMPLE_VALID,
  input  logic               i_SAMPLE_ACK,
  output logic [LVL_W-1:0]   o_FIFO_LEVEL,
  output logic [CNT_W-1:0]   o_OVERFLOW_CNT,
  output logic [CNT_W-1:0]   o_BAD_FRAME_CNT
);

  localparam int DATA_W = N_CH * SAMPLE_W;

  logic [STATUS_W-1:0] status_w;
  logic [DATA_W-1:0]   samples_w;
  logic [DATA_W-1:0]   head_w;
  logic                status_ok_w;
  logic                status_unused_w;
  logic                fifo_wr_w;
  logic                fifo_full_w;
  logic                fifo_empty_w;
  logic                pop_w;
  logic                xfer_w;
  logic                last_w;
  logic                ovf_inc_w;

  ser_state_e          state_q;
  logic [OUT_W-1:0]    data_q;
  logic [CH_W-1:0]     ch_q;
  logic                vld_q;
  logic [DATA_W-1:0]   shreg_q;
  logic [CNT_W-1:0]    ovf_q, ovf_d;

  function automatic logic [OUT_W-1:0] sext(input logic [SAMPLE_W-1:0] s);
    return OUT_W'($signed(s));
  endfunction

  assign status_w        = i_ADS1292_DATA_OUT[FRAME_W-1 -: STATUS_W];
  assign samples_w       = i_ADS1292_DATA_OUT[DATA_W-1:0];
  assign status_unused_w = ^status_w;

`ifdef ADS1292_STATUS_CHECK_EN
  assign status_ok_w = (status_w[STATUS_W-1 -: 4] == STATUS_SYNC_NIBBLE);
`else
  assign status_ok_w = 1'b1;
`endif

  assign fifo_wr_w = i_ADS1292_DATA_VALID && status_ok_w;
  assign xfer_w    = vld_q && i_SAMPLE_ACK;
  assign last_w    = (ch_q == CH_W'(N_CH-1));
  // Pop either to start from idle or to chain the next frame with no bubble.
  assign pop_w     = !fifo_empty_w &&
                     ((state_q == IDLE) || (state_q == EMIT && xfer_w && last_w));
  assign ovf_inc_w = fifo_wr_w && fifo_full_w && !pop_w;

  ads1292_frame_fifo #(
    .W     (DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i    (i_CLK),
    .rst_ni   (i_RSTN),
    .wr_en_i  (fifo_wr_w),
    .wr_dat_i (samples_w),
    .rd_en_i  (pop_w),
    .rd_dat_o (head_w),
    .full_o   (fifo_full_w),
    .empty_o  (fifo_empty_w),
    .level_o  (o_FIFO_LEVEL)
  );

  always_ff @(posedge i_CLK or negedge i_RSTN) begin
    if (!i_RSTN) begin
      state_q <= IDLE;
      data_q  <= '0;
      ch_q    <= '0;
      vld_q   <= 1'b0;
      shreg_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (!fifo_empty_w) begin
            data_q  <= sext(head_w[DATA_W-1 -: SAMPLE_W]);
            shreg_q <= head_w << SAMPLE_W;
            ch_q    <= '0;
            vld_q   <= 1'b1;
            state_q <= EMIT;
          end
        end
        EMIT: begin
          if (xfer_w) begin
            if (!last_w) begin
              data_q  <= sext(shreg_q[DATA_W-1 -: SAMPLE_W]);
              shreg_q <= shreg_q << SAMPLE_W;
              ch_q    <= ch_q + 1'b1;
            end else if (!fifo_empty_w) begin
              data_q  <= sext(head_w[DATA_W-1 -: SAMPLE_W]);
              shreg_q <= head_w << SAMPLE_W;
              ch_q    <= '0;
            end else begin
              vld_q   <= 1'b0;
              state_q <= IDLE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (ovf_inc_w) ovf_d = sat_inc(ovf_q);
  end

  always_ff @(posedge i_CLK or negedge i_RSTN) begin
    if (!i_RSTN) ovf_q <= '0;
    else         ovf_q <= ovf_d;
  end

`ifdef ADS1292_STATUS_CHECK_EN
  logic [CNT_W-1:0] bad_q, bad_d;

  always_comb begin
    bad_d = bad_q;
    if (i_ADS1292_DATA_VALID && !status_ok_w) bad_d = sat_inc(bad_q);
  end

  always_ff @(posedge i_CLK or negedge i_RSTN) begin
    if (!i_RSTN) bad_q <= '0;
    else         bad_q <= bad_d;
  end

  assign o_BAD_FRAME_CNT = bad_q;
`else
  assign o_BAD_FRAME_CNT = '0;
`endif

  assign o_SAMPLE_DATA  = data_q;
  assign o_SAMPLE_CH    = ch_q;
  assign o_SAMPLE_VALID = vld_q;
  assign o_OVERFLOW_CNT = ovf_q;

endmodule

// File: tb/tb_ads1292_frame_serializer.sv
// Scoreboard bench for ads1292_frame_serializer at default parameters (2 ch, 24-bit samples, 32-bit words, depth 4).
module tb_ads1292_frame_serializer;

  logic        clk;
  logic        rst_n;
  logic [71:0] frame;
  logic        frame_vld;
  logic [31:0] o_data;
  logic        o_ch;
  logic        o_vld;
  logic        ack;
  logic [2:0]  o_level;
  logic [15:0] o_ovf;
  logic [15:0] o_bad;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic        ch;
    logic [31:0] dat;
  } exp_t;

  exp_t exp_q[$];

  ads1292_frame_serializer dut (
    .i_CLK                (clk),
    .i_RSTN               (rst_n),
    .i_ADS1292_DATA_OUT   (frame),
    .i_ADS1292_DATA_VALID (frame_vld),
    .o_SAMPLE_DATA        (o_data),
    .o_SAMPLE_CH          (o_ch),
    .o_SAMPLE_VALID       (o_vld),
    .i_SAMPLE_ACK         (ack),
    .o_FIFO_LEVEL         (o_level),
    .o_OVERFLOW_CNT       (o_ovf),
    .o_BAD_FRAME_CNT      (o_bad)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [23:0] st, input logic [23:0] c0, input logic [23:0] c1,
                      input logic push_it, input logic [31:0] e0, input logic [31:0] e1);
    frame_vld = 1'b1;
    frame     = {st, c0, c1};
    if (push_it) begin
      exp_q.push_back(exp_t'({1'b0, e0}));
      exp_q.push_back(exp_t'({1'b1, e1}));
    end
    tick();
    frame_vld = 1'b0;
  endtask

  // Monitor: every accepted word must match the scoreboard head in order.
  always @(negedge clk) begin
    if (rst_n && o_vld && ack) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_word actual_ch=%0d actual_dat=%h expected=none", o_ch, o_data);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("word_ch", 64'(o_ch), 64'(e.ch));
        chk("word_dat", 64'(o_data), 64'(e.dat));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bit done;
    rst_n     = 1'b0;
    frame     = '0;
    frame_vld = 1'b0;
    ack       = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 64'(o_vld), 64'd0);
    chk("rst_data", 64'(o_data), 64'd0);
    chk("rst_ch", 64'(o_ch), 64'd0);
    chk("rst_level", 64'(o_level), 64'd0);
    chk("rst_ovf", 64'(o_ovf), 64'd0);
    chk("rst_bad", 64'(o_bad), 64'd0);
    rst_n = 1'b1;
    tick();

    // Single frame, ack held high: words in cycles 2 and 3.
    ack = 1'b1;
    send(24'hC00000, 24'h800001, 24'h123456, 1'b1, 32'hFF800001, 32'h00123456);
    chk("t1_c1_valid", 64'(o_vld), 64'd0);
    chk("t1_c1_level", 64'(o_level), 64'd1);
    tick();
    chk("t1_c2_valid", 64'(o_vld), 64'd1);
    chk("t1_c2_ch", 64'(o_ch), 64'd0);
    chk("t1_c2_data", 64'(o_data), 64'hFF800001);
    tick();
    chk("t1_c3_valid", 64'(o_vld), 64'd1);
    chk("t1_c3_ch", 64'(o_ch), 64'd1);
    chk("t1_c3_data", 64'(o_data), 64'h00123456);
    chk("t1_c3_level", 64'(o_level), 64'd0);
    tick();
    chk("t1_c4_valid", 64'(o_vld), 64'd0);

    // Backpressure: ack low for 5 cycles after valid rises.
    ack = 1'b0;
    repeat (2) tick();
    send(24'hC00000, 24'h7FFFFF, 24'hFFFFFE, 1'b1, 32'h007FFFFF, 32'hFFFFFFFE);
    tick();
    for (int i = 0; i < 5; i++) begin
      chk("t2_hold_valid", 64'(o_vld), 64'd1);
      chk("t2_hold_ch", 64'(o_ch), 64'd0);
      chk("t2_hold_data", 64'(o_data), 64'h007FFFFF);
      tick();
    end
    chk("t2_pre_ack_data", 64'(o_data), 64'h007FFFFF);
    ack = 1'b1;
    tick();
    chk("t2_ch1_ch", 64'(o_ch), 64'd1);
    chk("t2_ch1_data", 64'(o_data), 64'hFFFFFFFE);
    tick();
    chk("t2_end_valid", 64'(o_vld), 64'd0);
    chk("t2_end_level", 64'(o_level), 64'd0);

    // Overflow: six strobes with ack low, sixth dropped.
    ack = 1'b0;
    tick();
    for (int i = 0; i < 6; i++) begin
      frame_vld = 1'b1;
      frame     = {24'hC00000, 24'h000010 + 24'(i), 24'hF00000 + 24'(i)};
      if (i < 5) begin
        exp_q.push_back(exp_t'({1'b0, 32'h00000010 + 32'(i)}));
        exp_q.push_back(exp_t'({1'b1, 32'hFFF00000 + 32'(i)}));
      end
      tick();
    end
    frame_vld = 1'b0;
    chk("t3_level", 64'(o_level), 64'd4);
    chk("t3_ovf", 64'(o_ovf), 64'd1);
    chk("t3_head_data", 64'(o_data), 64'h00000010);
    ack  = 1'b1;
    done = 1'b0;
    for (int i = 0; i < 40 && !done; i++) begin
      tick();
      if (!o_vld && exp_q.size() == 0) done = 1'b1;
    end
    chk("t3_drain_done", 64'(done), 64'd1);
    chk("t3_drain_level", 64'(o_level), 64'd0);

    // Back-to-back frames, ack high: ch 0,1,0,1 with no bubble.
    tick();
    send(24'hC00000, 24'h000001, 24'h000002, 1'b1, 32'h00000001, 32'h00000002);
    send(24'hC00000, 24'hFFFFFF, 24'h400000, 1'b1, 32'hFFFFFFFF, 32'h00400000);
    chk("t4_c2_valid", 64'(o_vld), 64'd1);
    chk("t4_c2_ch", 64'(o_ch), 64'd0);
    tick();
    chk("t4_c3_valid", 64'(o_vld), 64'd1);
    chk("t4_c3_ch", 64'(o_ch), 64'd1);
    tick();
    chk("t4_c4_valid", 64'(o_vld), 64'd1);
    chk("t4_c4_ch", 64'(o_ch), 64'd0);
    chk("t4_c4_data", 64'(o_data), 64'hFFFFFFFF);
    tick();
    chk("t4_c5_valid", 64'(o_vld), 64'd1);
    chk("t4_c5_ch", 64'(o_ch), 64'd1);
    tick();
    chk("t4_c6_valid", 64'(o_vld), 64'd0);

    // Reset during a ch0 hold with two frames buffered.
    ack = 1'b0;
    tick();
    send(24'hC00000, 24'h0000AA, 24'h0000BB, 1'b0, 32'h0, 32'h0);
    send(24'hC00000, 24'h0000CC, 24'h0000DD, 1'b0, 32'h0, 32'h0);
    send(24'hC00000, 24'h0000EE, 24'h0000FF, 1'b0, 32'h0, 32'h0);
    chk("t5_pre_level", 64'(o_level), 64'd2);
    chk("t5_pre_valid", 64'(o_vld), 64'd1);
    chk("t5_pre_ovf", 64'(o_ovf), 64'd1);
    rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 64'(o_vld), 64'd0);
    chk("t5_rst_level", 64'(o_level), 64'd0);
    chk("t5_rst_ovf", 64'(o_ovf), 64'd0);
    tick();
    rst_n = 1'b1;
    ack   = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("t5_post_valid", 64'(o_vld), 64'd0);
    end

    // Frame with a bad status sync nibble.
`ifdef ADS1292_STATUS_CHECK_EN
    send(24'h400000, 24'h000123, 24'h000456, 1'b0, 32'h0, 32'h0);
    repeat (4) tick();
    chk("t6_bad_cnt", 64'(o_bad), 64'd1);
    chk("t6_level", 64'(o_level), 64'd0);
`else
    send(24'h400000, 24'h000123, 24'h000456, 1'b1, 32'h00000123, 32'h00000456);
    repeat (4) tick();
    chk("t6_bad_cnt", 64'(o_bad), 64'd0);
`endif
    chk("t6_ovf", 64'(o_ovf), 64'd0);
    send(24'hC00000, 24'h800000, 24'h7FFFFF, 1'b1, 32'hFF800000, 32'h007FFFFF);
    repeat (4) tick();
    chk("t6_good_valid", 64'(o_vld), 64'd0);

    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
